// File: rtl/uart_bus_responder.sv
// Memory-mapped UART peripheral on the CPU's MEM-stage data bus.
// Registers: TXD at BASE_ADDR, RXD at BASE_ADDR+4, CON at BASE_ADDR+8.
// CON = {rx_err, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en}.
// Ports:
//   clk, reset       - system clock, asynchronous active-high reset
//   mem_read         - bus read strobe; rdata is combinational
//   mem_write        - bus write strobe, committed at the rising clk edge
//   addr, wdata      - byte address (addr[1:0] ignored), store data
//   rdata            - load data
//   tx, rx           - serial output (idle high), serial input (async)
//   irq              - level interrupt request
module uart_bus_responder #(
  parameter int unsigned CLK_DIV   = 10417,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [29:0] TXD_WA = BASE_ADDR[31:2];
  localparam logic [29:0] RXD_WA = TXD_WA + 30'd1;
  localparam logic [29:0] CON_WA = TXD_WA + 30'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Registered state
  logic [1:0]       tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [7:0]       tx_byte, rx_shift, rx_data;
  logic             tx_busy, tx_done, rx_valid, rx_err, tx_irq_en, rx_irq_en;
  logic             rx_m, rx_s, rx_prev;

  // Next-state values
  logic [1:0]       tx_state_d, rx_state_d;
  logic [CNT_W-1:0] tx_cnt_d, rx_cnt_d;
  logic [2:0]       tx_bit_d, rx_bit_d;
  logic [7:0]       tx_byte_d, rx_shift_d, rx_data_d;
  logic             tx_busy_d, tx_d, tx_done_set, rx_set, rx_err_set;
  logic             tx_done_d, rx_valid_d, rx_err_d, tx_irq_en_d, rx_irq_en_d, irq_d;

  // Address decode and bus strobes
  logic hit_txd, hit_rxd, hit_con, wr_txd, wr_con, rd_rxd, rd_con;
  assign hit_txd = (addr[31:2] == TXD_WA);
  assign hit_rxd = (addr[31:2] == RXD_WA);
  assign hit_con = (addr[31:2] == CON_WA);
  assign wr_txd  = mem_write & hit_txd;
  assign wr_con  = mem_write & hit_con;
  assign rd_rxd  = mem_read & hit_rxd;
  assign rd_con  = mem_read & hit_con;

  // Combinational read mux so the CPU captures rdata in the same MEM cycle
  always_comb begin
    rdata = 32'd0;
    if (mem_read) begin
      if (hit_txd)      rdata = {24'd0, tx_byte};
      else if (hit_rxd) rdata = {24'd0, rx_data};
      else if (hit_con) rdata = {26'd0, rx_err, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
    end
  end

  // TX FSM: the accepting cycle only latches the byte; START begins on the next edge
  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt;
    tx_bit_d    = tx_bit;
    tx_byte_d   = tx_byte;
    tx_busy_d   = tx_busy;
    tx_d        = tx;
    tx_done_set = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (tx_busy) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end else if (wr_txd) begin
          tx_byte_d = wdata[7:0];
          tx_busy_d = 1'b1;
        end
      end
      S_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_byte[0];
        end else tx_cnt_d = tx_cnt + CNT_W'(1);
      end
      S_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit + 3'd1;
            tx_d     = tx_byte[tx_bit + 3'd1];
          end
        end else tx_cnt_d = tx_cnt + CNT_W'(1);
      end
      default: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = S_IDLE;
          tx_busy_d   = 1'b0;
          tx_done_set = 1'b1;
        end else tx_cnt_d = tx_cnt + CNT_W'(1);
      end
    endcase
  end

  // RX FSM: start edge, half-bit glitch check, then bit-centre sampling
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_set     = 1'b0;
    rx_err_set = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev & ~rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt + CNT_W'(1);
      end
      S_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_d = S_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end else rx_cnt_d = rx_cnt + CNT_W'(1);
      end
      default: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s) begin
            rx_data_d  = rx_shift;
            rx_set     = 1'b1;
            rx_err_set = rx_valid;
          end else begin
            rx_err_set = 1'b1;
          end
        end else rx_cnt_d = rx_cnt + CNT_W'(1);
      end
    endcase
  end

  // Status flags: hardware set wins over a same-cycle read clear
  always_comb begin
    tx_done_d   = tx_done_set | (tx_done & ~rd_con);
    rx_err_d    = rx_err_set | (rx_err & ~rd_con);
    rx_valid_d  = rx_set | (rx_valid & ~rd_rxd);
    tx_irq_en_d = wr_con ? wdata[0] : tx_irq_en;
    rx_irq_en_d = wr_con ? wdata[1] : rx_irq_en;
    irq_d       = (tx_done_d & tx_irq_en_d) | (rx_valid_d & rx_irq_en_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_byte   <= 8'd0;
      tx_busy   <= 1'b0;
      tx        <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'd0;
      rx_data   <= 8'd0;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_bit    <= tx_bit_d;
      tx_byte   <= tx_byte_d;
      tx_busy   <= tx_busy_d;
      tx        <= tx_d;
      rx_state  <= rx_state_d;
      rx_cnt    <= rx_cnt_d;
      rx_bit    <= rx_bit_d;
      rx_shift  <= rx_shift_d;
      rx_data   <= rx_data_d;
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_prev   <= rx_s;
      tx_done   <= tx_done_d;
      rx_valid  <= rx_valid_d;
      rx_err    <= rx_err_d;
      tx_irq_en <= tx_irq_en_d;
      rx_irq_en <= rx_irq_en_d;
      irq       <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder with CLK_DIV=16.
module tb_uart_bus_responder;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, rdata;
  logic        tx, rx, irq;

  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;
  logic rst_seen = 1'b0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_rx_last = 8'h00;

  uart_bus_responder #(.CLK_DIV(16), .BASE_ADDR(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge reset) rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_read = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    mem_read = 1'b0; addr = 32'd0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  // RXD read checked against the receive scoreboard
  task automatic read_rxd(input string tag);
    logic [31:0] d;
    bus_read(RXD, d);
    if (rx_q.size() != 0) m_rx_last = rx_q.pop_front();
    chk(tag, d, 32'(m_rx_last));
  endtask

  // Drives one serial frame; a good frame overwrites any unread byte
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    if (stop) begin
      rx_q.delete();
      rx_q.push_back(b);
    end
  endtask

  // TX monitor: samples near each bit centre and scores against tx_q
  initial begin
    logic [7:0] b;
    logic       st, sp;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (7) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx;
        end
        repeat (16) @(negedge clk);
        sp = tx;
        if (!rst_seen) begin
          n_frames++;
          chk("tx_start_bit", 32'(st), 32'd0);
          chk("tx_stop_bit", 32'(sp), 32'd1);
          if (tx_q.size() != 0) begin
            e = tx_q.pop_front();
            chk("tx_frame_byte", 32'(b), 32'(e));
          end else begin
            chk("tx_unexpected_frame", 32'(b), 32'hDEAD_0000);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    reset = 1'b1; rx = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'd0; wdata = 32'd0;

    // Reset values
    @(negedge clk);
    mem_read = 1'b1; addr = CON;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_con", rdata, 32'd0);
    mem_read = 1'b0; addr = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    read_chk("con_after_rst", CON, 32'h00);

    // TX frame 0xA5 with busy write ignored
    tx_q.push_back(8'hA5);
    bus_write(TXD, 32'h0000_00A5);
    chk("tx_high_at_write", 32'(tx), 32'd1);
    @(negedge clk);
    chk("tx_start_low", 32'(tx), 32'd0);
    repeat (15) @(negedge clk);
    chk("tx_start_len", 32'(tx), 32'd0);
    @(negedge clk);
    chk("tx_bit0_after_16", 32'(tx), 32'd1);
    bus_write(TXD, 32'h0000_003C);
    read_chk("con_busy", CON, 32'h10);
    read_chk("txd_kept", TXD, 32'hA5);
    repeat (200) @(negedge clk);
    read_chk("con_tx_done", CON, 32'h04);
    read_chk("con_cleared", CON, 32'h00);
    chk("irq_tx_masked", 32'(irq), 32'd0);

    // TX with interrupt enabled
    bus_write(CON, 32'h01);
    tx_q.push_back(8'h5C);
    bus_write(TXD, 32'h0000_005C);
    repeat (200) @(negedge clk);
    chk("irq_tx", 32'(irq), 32'd1);
    read_chk("con_tx_irq", CON, 32'h05);
    chk("irq_tx_clr", 32'(irq), 32'd0);
    bus_write(CON, 32'h00);

    // RX good byte with interrupt
    bus_write(CON, 32'h02);
    rx_frame(8'h5A, 1'b1);
    chk("irq_rx", 32'(irq), 32'd1);
    read_chk("con_rx_valid", CON, 32'h0A);
    read_rxd("rxd_5a");
    chk("irq_rx_clr", 32'(irq), 32'd0);
    read_chk("con_rx_clr", CON, 32'h02);

    // Framing error keeps rx_data
    rx_frame(8'h33, 1'b0);
    read_chk("con_frame_err", CON, 32'h22);
    read_rxd("rxd_after_ferr");

    // Glitch rejected
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    read_chk("con_glitch", CON, 32'h02);
    chk("irq_glitch", 32'(irq), 32'd0);

    // Overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    read_chk("con_overrun", CON, 32'h2A);
    read_rxd("rxd_overrun");

    // RXD read in the same cycle the stop sample lands: set wins
    fork
      rx_frame(8'h44, 1'b1);
      begin
        @(negedge clk);
        repeat (153) @(negedge clk);
        bus_read(RXD, d);
        chk("rxd_setwins_old", d, 32'h22);
      end
    join
    chk("irq_setwins", 32'(irq), 32'd1);
    read_chk("con_setwins", CON, 32'h0A);
    read_rxd("rxd_44");

    // Decode
    read_chk("unmapped_read", 32'h4000_0024, 32'h0);
    bus_write(CON, 32'hFF);
    read_chk("con_write_mask", CON, 32'h03);

    // Reset mid-frame
    bus_write(TXD, 32'h0000_0000);
    repeat (40) @(negedge clk);
    chk("tx_data_low", 32'(tx), 32'd0);
    #2 reset = 1'b1;
    #1 chk("tx_async_reset", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    read_chk("con_after_midrst", CON, 32'h00);
    chk("irq_after_midrst", 32'(irq), 32'd0);
    repeat (200) @(negedge clk);
    chk("tx_idle_end", 32'(tx), 32'd1);
    chk("tx_frames", 32'(n_frames), 32'd2);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
